// File: rtl/multicycle_core.sv
// Multi-cycle RV32I-subset core: a single ALU and a single memory port are shared
// between fetch, execute and data access, sequenced by a small FSM.
module multicycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic              illegal,
  output logic [31:0]       pc_dbg
);
  localparam int unsigned RIDX_W = $clog2(NUM_REGS);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_TRAP
  } state_t;

  state_t state, state_next;

  logic [31:0] pc, ir, a_reg, b_reg, imm_reg, alu_out, mdr;
  logic [31:0] regs [NUM_REGS];

  logic [6:0]  opcode, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic        is_op, is_opimm, is_lw, is_sw, is_br, is_jal, is_lui, is_ebreak;
  logic        known, bad_reg, alt, br_taken, take, tgt_bad, addr_ok;
  logic [31:0] imm_dec, alu_a, alu_b, alu_res, pc_plus4, wb_data;
  logic        req_c, we_c;
  logic [ADDR_W-1:0] addr_c;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign f3     = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign f7     = ir[31:25];

  always_comb begin
    is_op     = (opcode == 7'b0110011) &&
                ((f7 == 7'b0000000) || ((f7 == 7'b0100000) && (f3 == 3'b000 || f3 == 3'b101)));
    is_opimm  = 1'b0;
    if (opcode == 7'b0010011) begin
      case (f3)
        3'b001:  is_opimm = (f7 == 7'b0000000);
        3'b101:  is_opimm = (f7 == 7'b0000000) || (f7 == 7'b0100000);
        default: is_opimm = 1'b1;
      endcase
    end
    is_lw     = (opcode == 7'b0000011) && (f3 == 3'b010);
    is_sw     = (opcode == 7'b0100011) && (f3 == 3'b010);
    is_br     = (opcode == 7'b1100011) && (f3[2:1] == 2'b00);
    is_jal    = (opcode == 7'b1101111);
    is_lui    = (opcode == 7'b0110111);
    is_ebreak = (ir == 32'h0010_0073);
    known     = is_op | is_opimm | is_lw | is_sw | is_br | is_jal | is_lui | is_ebreak;
  end

  // Only the register fields a format actually uses are range-checked; the rest are immediate bits.
  always_comb begin
    bad_reg = 1'b0;
    if ((is_op | is_opimm | is_lw | is_sw | is_br) && (32'(rs1) >= NUM_REGS)) bad_reg = 1'b1;
    if ((is_op | is_sw | is_br) && (32'(rs2) >= NUM_REGS)) bad_reg = 1'b1;
    if ((is_op | is_opimm | is_lw | is_jal | is_lui) && (32'(rd) >= NUM_REGS)) bad_reg = 1'b1;
  end

  always_comb begin
    if (is_sw)       imm_dec = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    else if (is_br)  imm_dec = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    else if (is_jal) imm_dec = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
    else if (is_lui) imm_dec = {ir[31:12], 12'b0};
    else             imm_dec = {{20{ir[31]}}, ir[31:20]};
  end

  // The shared ALU also forms jump/branch targets (pc+imm) and load/store addresses (A+imm).
  always_comb begin
    alt     = ir[30] & (is_op | (is_opimm & (f3 == 3'b101)));
    alu_a   = (is_br || is_jal) ? pc : a_reg;
    alu_b   = is_op ? b_reg : imm_reg;
    alu_res = alu_a + alu_b;
    if (is_lui) begin
      alu_res = imm_reg;
    end else if (is_op || is_opimm) begin
      case (f3)
        3'b000:  alu_res = alt ? alu_a - alu_b : alu_a + alu_b;
        3'b001:  alu_res = alu_a << alu_b[4:0];
        3'b010:  alu_res = {31'b0, $signed(alu_a) < $signed(alu_b)};
        3'b011:  alu_res = {31'b0, alu_a < alu_b};
        3'b100:  alu_res = alu_a ^ alu_b;
        3'b101:  alu_res = alt ? $unsigned($signed(alu_a) >>> alu_b[4:0]) : alu_a >> alu_b[4:0];
        3'b110:  alu_res = alu_a | alu_b;
        default: alu_res = alu_a & alu_b;
      endcase
    end
  end

  assign pc_plus4 = pc + 32'd4;
  assign br_taken = (a_reg == b_reg) ^ f3[0];
  assign take     = is_jal | (is_br & br_taken);
  assign tgt_bad  = take & (alu_res[1:0] != 2'b00);
  assign addr_ok  = (alu_out[1:0] == 2'b00);
  assign wb_data  = is_lw ? mdr : (is_jal ? pc_plus4 : alu_out);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_FETCH;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_c      = 1'b0;
    we_c       = 1'b0;
    addr_c     = '0;
    case (state)
      S_FETCH: begin
        req_c  = 1'b1;
        addr_c = pc[ADDR_W-1:0];
        if (mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        if (!known || bad_reg) state_next = S_TRAP;
        else if (is_ebreak)    state_next = S_HALT;
        else                   state_next = S_EXEC;
      end
      S_EXEC: begin
        if (tgt_bad)              state_next = S_TRAP;
        else if (is_br)           state_next = S_FETCH;
        else if (is_lw || is_sw)  state_next = S_MEM;
        else                      state_next = S_WB;
      end
      S_MEM: begin
        if (!addr_ok) begin
          state_next = S_TRAP;
        end else begin
          req_c  = 1'b1;
          we_c   = is_sw;
          addr_c = alu_out[ADDR_W-1:0];
          if (mem_ready) state_next = is_sw ? S_FETCH : S_WB;
        end
      end
      S_WB:    state_next = S_FETCH;
      default: state_next = state;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc      <= RESET_PC;
      ir      <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      imm_reg <= '0;
      alu_out <= '0;
      mdr     <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_FETCH: if (mem_ready) ir <= mem_rdata;
        S_DECODE: begin
          a_reg   <= regs[rs1[RIDX_W-1:0]];
          b_reg   <= regs[rs2[RIDX_W-1:0]];
          imm_reg <= imm_dec;
        end
        S_EXEC: begin
          alu_out <= alu_res;
          if (is_br && !tgt_bad) pc <= br_taken ? alu_res : pc_plus4;
        end
        S_MEM: begin
          if (mem_ready && addr_ok) begin
            if (is_lw) mdr <= mem_rdata;
            else       pc  <= pc_plus4;
          end
        end
        S_WB: begin
          if (rd != 5'd0) regs[rd[RIDX_W-1:0]] <= wb_data;
          pc <= is_jal ? alu_out : pc_plus4;
        end
        default: ;
      endcase
    end
  end

  // Request outputs are gated by reset so an in-flight access is abandoned immediately.
  assign mem_req   = rst & req_c;
  assign mem_we    = rst & we_c;
  assign mem_addr  = rst ? addr_c : '0;
  assign mem_wdata = (rst & we_c) ? b_reg : '0;
  assign halted    = (state == S_HALT) || (state == S_TRAP);
  assign illegal   = (state == S_TRAP);
  assign pc_dbg    = pc;

endmodule
